msd_sequencer: RTL and testbench
================================

MSD_SEQUENCER -- requirements
Module: msd_sequencer

Interface
REQ-001 SHALL have parameter WORD_LENGHT, default 16, giving the operand/result width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum wait in any core-wait state.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1, synchronous, active-high reset).
REQ-004 SHALL have command ports: `cmd_valid` in 1; `cmd_ready` out 1; `cmd_opcode` in 2; `cmd_op_x` in WORD_LENGHT; `cmd_op_y` in WORD_LENGHT.
REQ-005 SHALL have response ports: `rsp_valid` out 1; `rsp_ready` in 1; `rsp_result` out WORD_LENGHT; `rsp_residue` out WORD_LENGHT; `rsp_error` out 1; `rsp_timeout` out 1.
REQ-006 SHALL have core-side outputs: `core_start` 1; `core_load` 1; `core_opcode` 2; `core_data` WORD_LENGHT.
REQ-007 SHALL have core-side inputs: `core_load_x` 1; `core_load_y` 1; `core_ready` 1; `core_error` 1; `core_result` WORD_LENGHT; `core_residue` WORD_LENGHT.

Function
REQ-008 SHALL use opcode encoding 00 divide, 01 sqrt, 10 multiply, 11 reserved.
REQ-009 SHALL implement states IDLE, START, LOAD_X, GAP, LOAD_Y, RUN, RESP.
REQ-010 SHALL assert `cmd_ready` only in IDLE; `cmd_valid & cmd_ready` captures opcode, op_x and op_y into internal registers.
REQ-011 SHALL, on a reserved opcode, go IDLE->RESP with `rsp_error`=1 and `rsp_result`=all ones, and never pulse `core_start`.
REQ-012 SHALL transition IDLE->START on a valid accept, and hold `core_start`=1 for exactly one cycle in START.
REQ-013 SHALL drive `core_opcode` from the captured opcode from START through RUN, and drive 0 elsewhere.
REQ-014 SHALL, in LOAD_X, hold `core_load`=1 and `core_data`=op_x until `core_load_x`=1 is sampled.
REQ-015 SHALL, when leaving LOAD_X, go to GAP for sqrt or divide/multiply alike; in GAP `core_load`=0 for one cycle.
REQ-016 SHALL leave GAP for RUN if the opcode is sqrt, and for LOAD_Y otherwise.
REQ-017 SHALL, in LOAD_Y, hold `core_load`=1 and `core_data`=op_y until `core_load_y`=1, then go to RUN.
REQ-018 SHALL, in RUN, wait for `core_ready`=1, capture `core_result`, `core_residue` and `core_error`, and go to RESP on the next cycle.
REQ-019 SHALL, if `core_error`=1 is sampled in any state from START through RUN, abort to RESP with `rsp_error`=1 and `rsp_result`=all ones.
REQ-020 SHALL have `core_ready` and `core_error` coinciding in RUN resolve as error.
REQ-021 SHALL hold `rsp_valid`=1 and all rsp_* stable in RESP until `rsp_ready`=1, then return to IDLE on the next cycle.
REQ-022 SHALL not accept a new command in the cycle RESP completes; earliest re-accept is the following IDLE cycle.
REQ-023 SHALL drive `core_data`=0 outside LOAD_X and LOAD_Y.
REQ-024 SHALL have a latency for a multiply with an immediately-acking core and ready at RUN entry+k of: accept at cycle 0, START at 1, LOAD_X at 2, GAP at 3, LOAD_Y at 4, RUN at 5, `rsp_valid` at 6+k.

Reset
REQ-025 SHALL, on `rst`=1 at a clock edge, force IDLE and clear all captured registers and the timeout counter.
REQ-026 SHALL reset outputs to: `cmd_ready`=1 after reset; all rsp_*, `core_start`, `core_load`, `core_opcode` and `core_data` to 0.
REQ-027 SHALL, on `rst` asserted mid-operation (any state), abandon the command without issuing a response.

Configuration
REQ-028 SHALL compile a timeout watchdog when MSD_SEQ_TIMEOUT_EN is defined; the counter clears on each state entry and increments in LOAD_X, LOAD_Y and RUN.
REQ-029 SHALL, with the watchdog, go to RESP when the count reaches TIMEOUT_CYCLES, with `rsp_timeout`=1, `rsp_error`=1 and `rsp_result`=all ones.
REQ-030 SHALL, without MSD_SEQ_TIMEOUT_EN, wait indefinitely, and tie `rsp_timeout` to 0.

Verification
REQ-031 SHALL cover a multiply: opcode 10, x=0x0007, y=0x0003; core returns result 0x0015 and residue 0 -> `rsp_result`=0x0015, `rsp_error`=0, one `core_start` pulse.
REQ-032 SHALL cover a sqrt: opcode 01, x=0x0031 -> no LOAD_Y entered, `core_load` high once; core returns 0x0007 -> `rsp_result`=0x0007.
REQ-033 SHALL cover a reserved opcode: opcode 11 -> `rsp_valid` within 2 cycles, `rsp_result`=0xFFFF, `rsp_error`=1, `core_start` never 1.
REQ-034 SHALL cover backpressure: `rsp_ready` held low for 10 cycles -> response stable and `cmd_ready`=0 throughout; IDLE is reached one cycle after `rsp_ready`.
REQ-035 SHALL cover a timeout (macro defined, TIMEOUT_CYCLES=8): `core_ready` never asserted -> `rsp_timeout`=1 and `rsp_error`=1 exactly 8 cycles after RUN entry.
REQ-036 SHALL cover reset mid-LOAD_Y: `rst` pulsed -> next cycle all outputs at reset values, no `rsp_valid`.

Source files
------------

// File: rtl/msd_sequencer.sv
// Command sequencer for a multi-cycle divide/sqrt/multiply core: accepts a command,
// loads operands into the core, waits for its result and returns a response.
// Define MSD_SEQ_TIMEOUT_EN to build the core-wait timeout watchdog.
module msd_sequencer #(
    parameter int WORD_LENGHT    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_opcode,
    input  logic [WORD_LENGHT-1:0] cmd_op_x,
    input  logic [WORD_LENGHT-1:0] cmd_op_y,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_LENGHT-1:0] rsp_result,
    output logic [WORD_LENGHT-1:0] rsp_residue,
    output logic                   rsp_error,
    output logic                   rsp_timeout,
    output logic                   core_start,
    output logic                   core_load,
    output logic [1:0]             core_opcode,
    output logic [WORD_LENGHT-1:0] core_data,
    input  logic                   core_load_x,
    input  logic                   core_load_y,
    input  logic                   core_ready,
    input  logic                   core_error,
    input  logic [WORD_LENGHT-1:0] core_result,
    input  logic [WORD_LENGHT-1:0] core_residue
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_LOAD_X = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_LOAD_Y = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    localparam logic [1:0] OP_SQRT = 2'b01;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [WORD_LENGHT-1:0] ONES = {WORD_LENGHT{1'b1}};
    localparam logic [WORD_LENGHT-1:0] ZERO = {WORD_LENGHT{1'b0}};

    logic [2:0]             state_q, state_d;
    logic [1:0]             opcode_q, opcode_d;
    logic [WORD_LENGHT-1:0] op_x_q, op_x_d, op_y_q, op_y_d;
    logic [WORD_LENGHT-1:0] rsp_result_q, rsp_result_d, rsp_residue_q, rsp_residue_d;
    logic                   rsp_error_q, rsp_error_d, rsp_timeout_q, rsp_timeout_d;
    logic                   cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    logic                   core_start_q, core_start_d, core_load_q, core_load_d;
    logic [1:0]             core_opcode_q, core_opcode_d;
    logic [WORD_LENGHT-1:0] core_data_q, core_data_d;
    logic                   timeout_hit;

`ifdef MSD_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Hitting LAST in a wait state means the count reaches TIMEOUT_CYCLES on this edge.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_counting;

    assign tmo_counting = (state_q == S_LOAD_X) || (state_q == S_LOAD_Y) || (state_q == S_RUN);
    assign timeout_hit  = tmo_counting && (tmo_cnt_q == TMO_LAST);

    // Watchdog count: restarts on every state change, advances only in core-wait states.
    always_comb begin
        if (state_d != state_q) begin
            tmo_cnt_d = {CW{1'b0}};
        end else if (tmo_counting) begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= {CW{1'b0}};
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next state, command capture and response capture.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        op_x_d        = op_x_q;
        op_y_d        = op_y_q;
        rsp_result_d  = rsp_result_q;
        rsp_residue_d = rsp_residue_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    opcode_d = cmd_opcode;
                    op_x_d   = cmd_op_x;
                    op_y_d   = cmd_op_y;
                    if (cmd_opcode == OP_RSV) begin
                        state_d      = S_RESP;
                        rsp_result_d = ONES;
                        rsp_error_d  = 1'b1;
                    end else begin
                        state_d = S_START;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START, S_LOAD_X, S_GAP, S_LOAD_Y, S_RUN: begin
                // A core error wins over everything, including a simultaneous core_ready.
                if (core_error) begin
                    state_d       = S_RESP;
                    rsp_result_d  = ONES;
                    rsp_residue_d = ZERO;
                    rsp_error_d   = 1'b1;
                end else if (timeout_hit) begin
                    state_d       = S_RESP;
                    rsp_result_d  = ONES;
                    rsp_residue_d = ZERO;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    case (state_q)
                        S_START:  state_d = S_LOAD_X;
                        S_LOAD_X: state_d = core_load_x ? S_GAP : S_LOAD_X;
                        S_GAP:    state_d = (opcode_q == OP_SQRT) ? S_RUN : S_LOAD_Y;
                        S_LOAD_Y: state_d = core_load_y ? S_RUN : S_LOAD_Y;
                        S_RUN: begin
                            if (core_ready) begin
                                state_d       = S_RESP;
                                rsp_result_d  = core_result;
                                rsp_residue_d = core_residue;
                                rsp_error_d   = 1'b0;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d       = S_IDLE;
                    rsp_result_d  = ZERO;
                    rsp_residue_d = ZERO;
                    rsp_error_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop.
    always_comb begin
        cmd_ready_d  = (state_d == S_IDLE);
        core_start_d = (state_d == S_START);
        core_load_d  = (state_d == S_LOAD_X) || (state_d == S_LOAD_Y);
        rsp_valid_d  = (state_d == S_RESP);
        if (state_d inside {S_START, S_LOAD_X, S_GAP, S_LOAD_Y, S_RUN}) begin
            core_opcode_d = opcode_d;
        end else begin
            core_opcode_d = 2'b00;
        end
        case (state_d)
            S_LOAD_X: core_data_d = op_x_d;
            S_LOAD_Y: core_data_d = op_y_d;
            default:  core_data_d = ZERO;
        endcase
    end

    // State, captured operands and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            opcode_q      <= 2'b00;
            op_x_q        <= ZERO;
            op_y_q        <= ZERO;
            rsp_result_q  <= ZERO;
            rsp_residue_q <= ZERO;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            core_start_q  <= 1'b0;
            core_load_q   <= 1'b0;
            core_opcode_q <= 2'b00;
            core_data_q   <= ZERO;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            op_x_q        <= op_x_d;
            op_y_q        <= op_y_d;
            rsp_result_q  <= rsp_result_d;
            rsp_residue_q <= rsp_residue_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            core_start_q  <= core_start_d;
            core_load_q   <= core_load_d;
            core_opcode_q <= core_opcode_d;
            core_data_q   <= core_data_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_residue = rsp_residue_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign core_start  = core_start_q;
    assign core_load   = core_load_q;
    assign core_opcode = core_opcode_q;
    assign core_data   = core_data_q;

endmodule

// File: tb/tb_msd_sequencer.sv
// Directed self-checking bench for msd_sequencer; timeout checks depend on MSD_SEQ_TIMEOUT_EN.
module tb_msd_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]   cmd_opcode, core_opcode;
    logic [W-1:0] cmd_op_x, cmd_op_y, rsp_result, rsp_residue, core_data, core_result, core_residue;
    logic         rsp_error, rsp_timeout, core_start, core_load;
    logic         core_load_x, core_load_y, core_ready, core_error;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    int load_cnt = 0;
    int s0, l0;

    msd_sequencer #(.WORD_LENGHT(W), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_op_x(cmd_op_x), .cmd_op_y(cmd_op_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_residue(rsp_residue), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .core_start(core_start), .core_load(core_load), .core_opcode(core_opcode),
        .core_data(core_data), .core_load_x(core_load_x), .core_load_y(core_load_y),
        .core_ready(core_ready), .core_error(core_error),
        .core_result(core_result), .core_residue(core_residue)
    );

    always #5 clk = ~clk;

    // Cycle counts of core_start and core_load, sampled mid-cycle.
    always @(negedge clk) begin
        if (core_start) start_cnt <= start_cnt + 1;
        if (core_load)  load_cnt  <= load_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_op_x   = x;
        cmd_op_y   = y;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_idle_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_idle_rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 2'b00; cmd_op_x = 16'h0000; cmd_op_y = 16'h0000;
        rsp_ready = 1'b0; core_load_x = 1'b0; core_load_y = 1'b0; core_ready = 1'b0;
        core_error = 1'b0; core_result = 16'h0000; core_residue = 16'h0000;
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_load", core_load, 0);
        chk("rst_core_opcode", core_opcode, 0);
        chk("rst_core_data", core_data, 0);
        chk("rst_rsp_result", rsp_result, 0);
        rst = 1'b0;
        tick();

        // Multiply 7*3 with an immediately acking core, ready at RUN entry.
        s0 = start_cnt;
        core_load_x = 1'b1; core_load_y = 1'b1;
        issue(2'b10, 16'h0007, 16'h0003);
        chk("mul_start", core_start, 1);
        chk("mul_start_op", core_opcode, 2);
        chk("mul_cmd_ready_busy", cmd_ready, 0);
        tick();
        chk("mul_ldx_load", core_load, 1);
        chk("mul_ldx_data", core_data, 16'h0007);
        chk("mul_ldx_start_low", core_start, 0);
        tick();
        chk("mul_gap_load", core_load, 0);
        chk("mul_gap_data", core_data, 0);
        tick();
        chk("mul_ldy_load", core_load, 1);
        chk("mul_ldy_data", core_data, 16'h0003);
        tick();
        chk("mul_run_load", core_load, 0);
        chk("mul_run_op", core_opcode, 2);
        chk("mul_run_no_rsp", rsp_valid, 0);
        core_ready = 1'b1; core_result = 16'h0015; core_residue = 16'h0000;
        tick();
        core_ready = 1'b0;
        chk("mul_rsp_valid", rsp_valid, 1);
        chk("mul_rsp_result", rsp_result, 16'h0015);
        chk("mul_rsp_residue", rsp_residue, 0);
        chk("mul_rsp_error", rsp_error, 0);
        chk("mul_rsp_op_zero", core_opcode, 0);
        chk("mul_start_pulses", start_cnt - s0, 1);
        release_rsp("mul");

        // Sqrt of 0x31: LOAD_Y skipped, core_load high for one cycle only.
        l0 = load_cnt;
        issue(2'b01, 16'h0031, 16'h0000);
        chk("sqrt_start", core_start, 1);
        tick();
        chk("sqrt_ldx_data", core_data, 16'h0031);
        tick();
        tick();
        chk("sqrt_run_no_load", core_load, 0);
        chk("sqrt_run_op", core_opcode, 1);
        core_ready = 1'b1; core_result = 16'h0007; core_residue = 16'h0000;
        tick();
        core_ready = 1'b0;
        chk("sqrt_rsp_valid", rsp_valid, 1);
        chk("sqrt_rsp_result", rsp_result, 16'h0007);
        chk("sqrt_rsp_error", rsp_error, 0);
        chk("sqrt_load_cycles", load_cnt - l0, 1);
        release_rsp("sqrt");

        // Divide aborted by core_error while waiting in LOAD_X.
        core_load_x = 1'b0;
        issue(2'b00, 16'h0064, 16'h0005);
        tick(); tick();
        chk("div_ldx_wait_load", core_load, 1);
        chk("div_ldx_wait_data", core_data, 16'h0064);
        core_error = 1'b1;
        tick();
        core_error = 1'b0;
        chk("div_err_valid", rsp_valid, 1);
        chk("div_err_flag", rsp_error, 1);
        chk("div_err_result", rsp_result, 16'hFFFF);
        chk("div_err_no_load", core_load, 0);
        release_rsp("div_err");

        // core_ready and core_error together in RUN resolve as error.
        core_load_x = 1'b1;
        issue(2'b01, 16'h0031, 16'h0000);
        tick(); tick(); tick();
        core_ready = 1'b1; core_error = 1'b1; core_result = 16'h0007;
        tick();
        core_ready = 1'b0; core_error = 1'b0;
        chk("both_valid", rsp_valid, 1);
        chk("both_error", rsp_error, 1);
        chk("both_result", rsp_result, 16'hFFFF);
        release_rsp("both");

        // Core that never answers: watchdog fires 8 cycles after RUN entry, or we keep waiting.
        issue(2'b01, 16'h0010, 16'h0000);
        tick(); tick(); tick();
        chk("wd_run_entry_op", core_opcode, 1);
`ifdef MSD_SEQ_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("wd_not_yet", rsp_valid, 0);
        end
        tick();
        chk("wd_valid", rsp_valid, 1);
        chk("wd_timeout", rsp_timeout, 1);
        chk("wd_error", rsp_error, 1);
        chk("wd_result", rsp_result, 16'hFFFF);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("wd_waiting", rsp_valid, 0);
        end
        core_ready = 1'b1; core_result = 16'h0042;
        tick();
        core_ready = 1'b0;
        chk("wd_late_valid", rsp_valid, 1);
        chk("wd_late_result", rsp_result, 16'h0042);
        chk("wd_timeout_tied", rsp_timeout, 0);
`endif
        release_rsp("wd");

        // Reserved opcode then 10 cycles of backpressure.
        s0 = start_cnt;
        issue(2'b11, 16'h1234, 16'h5678);
        chk("rsv_valid", rsp_valid, 1);
        chk("rsv_result", rsp_result, 16'hFFFF);
        chk("rsv_error", rsp_error, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 16'hFFFF);
            chk("bp_error", rsp_error, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        chk("rsv_no_start", start_cnt - s0, 0);

        // Command offered while RESP completes must wait for the next IDLE cycle.
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_opcode = 2'b10;
        cmd_op_x = 16'h0005; cmd_op_y = 16'h0009; core_load_y = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk("reacc_idle_ready", cmd_ready, 1);
        chk("reacc_idle_no_start", core_start, 0);
        chk("reacc_idle_no_rsp", rsp_valid, 0);
        tick();
        cmd_valid = 1'b0;
        chk("reacc_start", core_start, 1);
        tick(); tick(); tick(); tick();
        chk("rstmid_ldy_load", core_load, 1);
        chk("rstmid_ldy_data", core_data, 16'h0009);

        // Reset pulse mid-LOAD_Y abandons the command.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_cmd_ready", cmd_ready, 1);
        chk("rstmid_load", core_load, 0);
        chk("rstmid_data", core_data, 0);
        chk("rstmid_opcode", core_opcode, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_rsp_error", rsp_error, 0);
        tick();
        chk("rstmid_after_rsp", rsp_valid, 0);
        chk("rstmid_after_ready", cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
